gshare_history_indexer: RTL and testbench
=========================================

Name: gshare_history_indexer

Overview:
- Upstream stage of the pattern history table (PHT).
- Keeps the speculative and retired global branch history registers (GHR).
- Forms the gshare PHT read index from the fetch PC and the speculative GHR.
- Checkpoints history and index per in-flight branch. On resolution it emits the PHT update address and direction, and repairs the GHR after a mispredict or flush.

Parameters:
- PC_W, 32, fetch PC width.
- IDX_W, 10, PHT address width.
- HIST_W, 10, GHR length. Must satisfy 1 ≤ HIST_W ≤ IDX_W.
- CKPT_DEPTH, 4, number of in-flight branch checkpoints. Power of two.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- stall  in  1  pipeline stall; freezes all state.
- fetch_valid  in  1  a conditional branch is being predicted this cycle.
- fetch_pc  in  PC_W  PC of that branch.
- pred_dir  in  1  PHT prediction for pht_addr, returned in the same cycle.
- pht_addr  out  IDX_W  PHT read index (combinational).
- ckpt_id  out  log2(CKPT_DEPTH)  tag assigned to the branch being fetched.
- ckpt_full  out  1  checkpoint queue full; fetch must hold.
- resolve_valid  in  1  oldest in-flight branch resolved in ID.
- resolve_id  in  log2(CKPT_DEPTH)  tag of the resolving branch.
- resolve_dir  in  1  actual direction.
- resolve_mispredict  in  1  actual direction differs from the prediction.
- flush  in  1  full pipeline flush (exception/eret).
- upd_valid  out  1  PHT update strobe.
- upd_addr  out  IDX_W  PHT index to update.
- upd_dir  out  1  direction to train.
- proto_err  out  1  sticky: resolve_id did not match the queue head.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - spec_ghr, ret_ghr, head, tail and count cleared to 0.
  - upd_valid, upd_addr, upd_dir and proto_err cleared to 0.
- Index: pht_addr = fetch_pc[IDX_W+1:2] XOR zero-extended spec_ghr. Purely combinational.
- ckpt_id = tail. ckpt_full = (count == CKPT_DEPTH), computed from the registered count only.
- Push, when fetch_valid & !stall & !ckpt_full & !mispredict-this-cycle & !flush:
  - Write {spec_ghr (pre-shift), pht_addr} into the queue at tail.
  - tail++ (wraps modulo CKPT_DEPTH).
  - spec_ghr <= {spec_ghr[HIST_W-2:0], pred_dir}.
- Pop, when resolve_valid & !stall:
  - Pop the head entry.
  - If resolve_id ≠ head, set proto_err and still pop.
  - If count == 0, set proto_err and ignore the pop.
  - Next cycle: upd_valid=1, upd_addr=entry.idx, upd_dir=resolve_dir. Latency is 1 cycle from resolve to the update strobe.
  - ret_ghr <= {ret_ghr[HIST_W-2:0], resolve_dir}.
- Mispredict (popped with resolve_mispredict=1):
  - spec_ghr <= {entry.ghr[HIST_W-2:0], resolve_dir}.
  - All younger entries are discarded: tail <= head+1, count <= 0.
  - A same-cycle push is dropped.
- Flush:
  - spec_ghr <= ret_ghr after any same-cycle pop has been applied.
  - count=0, head=tail.
  - Same-cycle push is dropped; a same-cycle pop still produces upd_valid.
- Push and pop in the same cycle with no mispredict: count is unchanged. A push while full stays blocked even if a pop frees an entry that cycle.
- Stall:
  - All registers hold.
  - upd_valid is forced to 0 during a stall cycle. It is a one-cycle pulse and is never repeated.
- Reset mid-operation discards all checkpoints. No update is emitted.
- HIST_W == 1: the shift reduces to a direct load of the direction.

Optional Feature:
- Macro: GSHARE_XOR_EN.
- Defined: the index is the gshare XOR described above.
- Undefined:
  - pht_addr = fetch_pc[IDX_W+1:2] (bimodal).
  - The GHRs are still maintained so recovery logic is identical.
  - Test expectations in bimodal mode use the PC bits only.

Decomposition:
- Shared package/defines.v holds:
  - True_v, False_v and RstEnable.
  - SIZE_OF_PHT_ADDR, tied to IDX_W.
  - A SIZE_OF_GHR macro, tied to HIST_W.
  - The CKPT_DEPTH default.
- One sub-module: bp_ckpt_fifo.
  - Circular buffer with head/tail/count.
  - Push, pop and truncate-after-head operations.
  - Exposes head_entry combinationally.

Test Plan:
- Reset then fetch_valid, pc=0x0000_0010, pred_dir=1:
  - pht_addr=0x004.
  - Next cycle spec_ghr=0x001 and the following fetch at pc=0x10 gives pht_addr=0x005.
- Four pushes with no resolve:
  - ckpt_full=1.
  - A 5th fetch leaves spec_ghr and tail unchanged.
  - One resolve drops ckpt_full the next cycle.
- Push ids 0,1,2 with pred 1,1,1, then resolve id0 dir=0 with mispredict:
  - spec_ghr = 0b0 (checkpoint 0 shifted with 0).
  - count=0.
  - upd_valid=1, upd_addr=entry0.idx, upd_dir=0 one cycle later.
- Resolve with correct prediction plus flush in the same cycle:
  - ret_ghr shifts in the direction.
  - spec_ghr equals the new ret_ghr.
  - upd_valid pulses once.
- Stall held for 3 cycles during resolve_valid:
  - No state change and upd_valid=0 throughout.
  - The pulse appears exactly once after the stall drops.
- resolve_id=2 while the head is 0 → proto_err=1 (sticky), and the head entry is popped.

Source files
------------

// File: rtl/gshare_history_indexer_pkg.sv
// Shared constants and types for the gshare history indexer slice.
// SIZE_OF_GHR sets the default global-history length.
`ifndef SIZE_OF_GHR
`define SIZE_OF_GHR 10
`endif

package gshare_history_indexer_pkg;
    localparam logic True_v    = 1'b1;
    localparam logic False_v   = 1'b0;
    localparam logic RstEnable = 1'b0;

    localparam int PC_W_DEF         = 32;
    localparam int SIZE_OF_PHT_ADDR = 10;
    localparam int HIST_W_DEF       = `SIZE_OF_GHR;
    localparam int CKPT_DEPTH_DEF   = 4;

    // Recovery action applied to the checkpoint queue in one cycle.
    typedef enum logic [1:0] {
        REC_NONE  = 2'd0,
        REC_TRUNC = 2'd1,
        REC_CLEAR = 2'd2
    } ckpt_rec_e;
endpackage

// File: rtl/gshare_history_indexer_if.sv
// Fetch/resolve/update bundle between the branch pipeline (master)
// and the gshare history indexer (slave).
interface gshare_history_indexer_if
    import gshare_history_indexer_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int IDX_W      = SIZE_OF_PHT_ADDR,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF
) ();
    localparam int ID_W = $clog2(CKPT_DEPTH);

    logic             stall;
    logic             fetch_valid;
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_dir;
    logic [IDX_W-1:0] pht_addr;
    logic [ID_W-1:0]  ckpt_id;
    logic             ckpt_full;
    logic             resolve_valid;
    logic [ID_W-1:0]  resolve_id;
    logic             resolve_dir;
    logic             resolve_mispredict;
    logic             flush;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_dir;
    logic             proto_err;

    modport master (
        output stall, fetch_valid, fetch_pc, pred_dir,
               resolve_valid, resolve_id, resolve_dir, resolve_mispredict, flush,
        input  pht_addr, ckpt_id, ckpt_full, upd_valid, upd_addr, upd_dir, proto_err
    );

    modport slave (
        input  stall, fetch_valid, fetch_pc, pred_dir,
               resolve_valid, resolve_id, resolve_dir, resolve_mispredict, flush,
        output pht_addr, ckpt_id, ckpt_full, upd_valid, upd_addr, upd_dir, proto_err
    );
endinterface

// File: rtl/gshare_history_indexer_bp_ckpt_fifo.sv
// Circular checkpoint buffer: push at tail, pop at head, and recovery
// by truncating after the head or clearing everything in flight.
module bp_ckpt_fifo
    import gshare_history_indexer_pkg::*;
#(
    parameter  int ENTRY_W = 20,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_entry,
    input  logic               i_pop,
    input  ckpt_rec_e          i_rec,
    output logic [ENTRY_W-1:0] o_head_entry,
    output logic [PTR_W-1:0]   o_head,
    output logic [PTR_W-1:0]   o_tail,
    output logic               o_full,
    output logic               o_empty
);
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_head_inc;

    assign w_head_inc = r_head + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            unique case (i_rec)
                REC_TRUNC: begin
                    r_head  <= w_head_inc;
                    r_tail  <= w_head_inc;
                    r_count <= '0;
                end
                REC_CLEAR: begin
                    r_head  <= r_tail;
                    r_count <= '0;
                end
                default: begin
                    if (i_push) r_tail <= r_tail + 1'b1;
                    if (i_pop)  r_head <= w_head_inc;
                    if (i_push && !i_pop)      r_count <= r_count + 1'b1;
                    else if (!i_push && i_pop) r_count <= r_count - 1'b1;
                end
            endcase
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by head/tail/count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_tail] <= i_push_entry;
    end

    assign o_head_entry = r_mem[r_head];
    assign o_head       = r_head;
    assign o_tail       = r_tail;
    assign o_full       = (r_count == CNT_W'(DEPTH));
    assign o_empty      = (r_count == '0);
endmodule

// File: rtl/gshare_history_indexer.sv
// Speculative/retired GHR keeper and PHT index former for the predictor.
// Define GSHARE_XOR_EN for the gshare XOR index; otherwise the index is bimodal (PC only).
module gshare_history_indexer
    import gshare_history_indexer_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int IDX_W      = SIZE_OF_PHT_ADDR,
    parameter int HIST_W     = HIST_W_DEF,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF
) (
    input logic clk,
    input logic resetn,
    gshare_history_indexer_if.slave bus
);
    localparam int ID_W    = $clog2(CKPT_DEPTH);
    localparam int ENTRY_W = HIST_W + IDX_W;

    logic [HIST_W-1:0]  r_spec_ghr;
    logic [HIST_W-1:0]  r_ret_ghr;
    logic               r_upd_valid;
    logic [IDX_W-1:0]   r_upd_addr;
    logic               r_upd_dir;
    logic               r_proto_err;

    logic [HIST_W-1:0]  w_spec_ghr_nxt;
    logic [HIST_W-1:0]  w_ret_ghr_nxt;
    logic [IDX_W-1:0]   w_pc_idx;
    logic [IDX_W-1:0]   w_idx;
    logic [ENTRY_W-1:0] w_head_entry;
    logic [HIST_W-1:0]  w_head_ghr;
    logic [IDX_W-1:0]   w_head_idx;
    logic [ID_W-1:0]    w_head;
    logic [ID_W-1:0]    w_tail;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_mispredict;
    logic               w_flush;
    logic               w_push;
    logic               w_bad_id;
    logic               w_unused_pc;
    ckpt_rec_e          w_rec;

    // Shift one direction into a history; with HIST_W == 1 this is a plain load.
    function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] ghr, input logic dir);
        logic [HIST_W:0] w_cat;
        w_cat = {ghr, dir};
        return w_cat[HIST_W-1:0];
    endfunction

    assign w_pc_idx    = bus.fetch_pc[IDX_W+1:2];
    assign w_unused_pc = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0]};

`ifdef GSHARE_XOR_EN
    logic [IDX_W-1:0] w_ghr_ext;
    always_comb begin
        w_ghr_ext               = '0;
        w_ghr_ext[HIST_W-1:0]   = r_spec_ghr;
    end
    assign w_idx = w_pc_idx ^ w_ghr_ext;
`else
    assign w_idx = w_pc_idx;
`endif

    assign {w_head_ghr, w_head_idx} = w_head_entry;

    // An empty-queue resolve is a protocol error and does not pop.
    assign w_pop        = bus.resolve_valid & ~bus.stall & ~w_empty;
    assign w_mispredict = w_pop & bus.resolve_mispredict;
    assign w_flush      = bus.flush & ~bus.stall;
    assign w_push       = bus.fetch_valid & ~bus.stall & ~w_full & ~w_mispredict & ~bus.flush;
    assign w_bad_id     = bus.resolve_valid & ~bus.stall & (w_empty | (bus.resolve_id != w_head));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_rec = REC_NONE;
        if (w_flush)           w_rec = REC_CLEAR;
        else if (w_mispredict) w_rec = REC_TRUNC;

        w_ret_ghr_nxt = r_ret_ghr;
        if (w_pop) w_ret_ghr_nxt = shift_in(r_ret_ghr, bus.resolve_dir);

        w_spec_ghr_nxt = r_spec_ghr;
        if (w_flush)           w_spec_ghr_nxt = w_ret_ghr_nxt;
        else if (w_mispredict) w_spec_ghr_nxt = shift_in(w_head_ghr, bus.resolve_dir);
        else if (w_push)       w_spec_ghr_nxt = shift_in(r_spec_ghr, bus.pred_dir);
    end

    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            r_spec_ghr  <= '0;
            r_ret_ghr   <= '0;
            r_upd_valid <= False_v;
            r_upd_addr  <= '0;
            r_upd_dir   <= False_v;
            r_proto_err <= False_v;
        end else begin
            r_spec_ghr  <= w_spec_ghr_nxt;
            r_ret_ghr   <= w_ret_ghr_nxt;
            r_upd_valid <= w_pop;
            if (w_pop) begin
                r_upd_addr <= w_head_idx;
                r_upd_dir  <= bus.resolve_dir;
            end
            if (w_bad_id) r_proto_err <= True_v;
        end
    end

    bp_ckpt_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (CKPT_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (w_push),
        .i_push_entry ({r_spec_ghr, w_idx}),
        .i_pop        (w_pop),
        .i_rec        (w_rec),
        .o_head_entry (w_head_entry),
        .o_head       (w_head),
        .o_tail       (w_tail),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign bus.pht_addr  = w_idx;
    assign bus.ckpt_id   = w_tail;
    assign bus.ckpt_full = w_full;
    assign bus.upd_valid = r_upd_valid & ~bus.stall;
    assign bus.upd_addr  = r_upd_addr;
    assign bus.upd_dir   = r_upd_dir;
    assign bus.proto_err = r_proto_err;
endmodule

// File: tb/tb_gshare_history_indexer.sv
// Scenario tasks plus a randomized run against a queue-based model of the indexer.
module tb_gshare_history_indexer;
    import gshare_history_indexer_pkg::*;

    localparam int IDX_W  = 10;
    localparam int HIST_W = 10;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 2;
    localparam int HMASK  = (1 << HIST_W) - 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gshare_history_indexer_if bus ();
    gshare_history_indexer dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int ghr; int idx; } ent_t;
    ent_t m_q[$];
    int   m_spec, m_ret, m_head, m_tail, m_ua;
    bit   m_uv, m_ud, m_proto;

    function automatic int pc_bits(input logic [31:0] pc);
        return int'(pc >> 2) & ((1 << IDX_W) - 1);
    endfunction

    function automatic int exp_idx(input logic [31:0] pc);
`ifdef GSHARE_XOR_EN
        return pc_bits(pc) ^ m_spec;
`else
        return pc_bits(pc);
`endif
    endfunction

    // Reference behaviour for one clock edge, from the currently driven inputs.
    task automatic model_step();
        bit   pop, mis, push;
        ent_t e;
        if (!resetn) begin
            m_q.delete();
            m_spec = 0; m_ret = 0; m_head = 0; m_tail = 0;
            m_uv = 0; m_ua = 0; m_ud = 0; m_proto = 0;
            return;
        end
        if (bus.stall) begin
            m_uv = 0;
            return;
        end
        pop = bus.resolve_valid && (m_q.size() > 0);
        if (bus.resolve_valid && (m_q.size() == 0 || int'(bus.resolve_id) != m_head)) m_proto = 1;
        mis  = pop && bus.resolve_mispredict;
        push = bus.fetch_valid && (m_q.size() < DEPTH) && !mis && !bus.flush;
        m_uv = pop;
        if (pop) begin
            e = m_q.pop_front();
            m_ua = e.idx;
            m_ud = bus.resolve_dir;
            m_head = (m_head + 1) % DEPTH;
            m_ret = ((m_ret << 1) | int'(bus.resolve_dir)) & HMASK;
        end
        if (push) begin
            m_q.push_back('{m_spec, exp_idx(bus.fetch_pc)});
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (bus.flush) begin
            m_q.delete();
            m_head = m_tail;
            m_spec = m_ret;
        end else if (mis) begin
            m_q.delete();
            m_tail = m_head;
            m_spec = ((e.ghr << 1) | int'(bus.resolve_dir)) & HMASK;
        end else if (push) begin
            m_spec = ((m_spec << 1) | int'(bus.pred_dir)) & HMASK;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.fetch_valid = 0; bus.fetch_pc = '0; bus.pred_dir = 0;
        bus.resolve_valid = 0; bus.resolve_id = '0; bus.resolve_dir = 0;
        bus.resolve_mispredict = 0; bus.flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic pd);
        bus.fetch_valid = 1; bus.fetch_pc = pc; bus.pred_dir = pd;
        tick();
        bus.fetch_valid = 0;
    endtask

    task automatic resolve_one(input int id, input logic dir, input logic mis, input logic fl);
        bus.resolve_valid = 1; bus.resolve_id = ID_W'(id); bus.resolve_dir = dir;
        bus.resolve_mispredict = mis; bus.flush = fl;
        tick();
        bus.resolve_valid = 0; bus.resolve_mispredict = 0; bus.flush = 0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.fetch_pc = 32'h10;
        #1;
        n_tests++; if (bus.pht_addr !== 10'h004) begin n_fail++; $display("FAIL reset_pht_addr got=%h exp=004", bus.pht_addr); end
        n_tests++; if (bus.ckpt_id !== 2'd0) begin n_fail++; $display("FAIL reset_ckpt_id got=%0d exp=0", bus.ckpt_id); end
        n_tests++; if (bus.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL reset_ckpt_full got=%b exp=0", bus.ckpt_full); end
        n_tests++; if (bus.upd_valid !== 1'b0 || bus.upd_addr !== '0 || bus.upd_dir !== 1'b0) begin
            n_fail++; $display("FAIL reset_upd got=%b/%h/%b exp=0/000/0", bus.upd_valid, bus.upd_addr, bus.upd_dir); end
        n_tests++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err); end
        // Reset arriving with a resolve pending must discard it.
        push_one($urandom, 1);
        push_one($urandom, 0);
        bus.resolve_valid = 1; bus.resolve_id = 0; resetn = 0;
        tick();
        resetn = 1; bus.resolve_valid = 0;
        n_tests++; if (bus.upd_valid !== 1'b0 || bus.ckpt_id !== 2'd0) begin
            n_fail++; $display("FAIL midreset_state got upd=%b id=%0d exp upd=0 id=0", bus.upd_valid, bus.ckpt_id); end
        tick();
        n_tests++; if (bus.upd_valid !== 1'b0 || dut.r_spec_ghr !== '0) begin
            n_fail++; $display("FAIL midreset_after got upd=%b ghr=%h exp 0/000", bus.upd_valid, dut.r_spec_ghr); end
    endtask

    task automatic test_index();
        logic [IDX_W-1:0] exp2;
        do_reset();
        bus.fetch_valid = 1; bus.fetch_pc = 32'h10; bus.pred_dir = 1;
        #1;
        n_tests++; if (bus.pht_addr !== 10'h004) begin n_fail++; $display("FAIL index_first got=%h exp=004", bus.pht_addr); end
        tick();
`ifdef GSHARE_XOR_EN
        exp2 = 10'h005;
`else
        exp2 = 10'h004;
`endif
        n_tests++; if (bus.pht_addr !== exp2) begin n_fail++; $display("FAIL index_second got=%h exp=%h", bus.pht_addr, exp2); end
        n_tests++; if (dut.r_spec_ghr !== 10'h001) begin n_fail++; $display("FAIL index_spec_ghr got=%h exp=001", dut.r_spec_ghr); end
        n_tests++; if (bus.ckpt_id !== 2'd1) begin n_fail++; $display("FAIL index_ckpt_id got=%0d exp=1", bus.ckpt_id); end
        bus.fetch_valid = 0;
    endtask

    task automatic test_full();
        int saved_spec;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one($urandom, 1'($urandom_range(0, 1)));
        n_tests++; if (bus.ckpt_full !== 1'b1 || bus.ckpt_id !== 2'd0) begin
            n_fail++; $display("FAIL full_flag got full=%b id=%0d exp full=1 id=0", bus.ckpt_full, bus.ckpt_id); end
        saved_spec = m_spec;
        bus.fetch_valid = 1; bus.fetch_pc = $urandom; bus.pred_dir = 1;
        tick();
        n_tests++; if (bus.ckpt_id !== 2'd0 || dut.r_spec_ghr !== HIST_W'(saved_spec)) begin
            n_fail++; $display("FAIL full_blocked got id=%0d ghr=%h exp id=0 ghr=%h", bus.ckpt_id, dut.r_spec_ghr, saved_spec); end
        // Pop while fetch is still held: the push stays blocked this cycle.
        bus.resolve_valid = 1; bus.resolve_id = 0; bus.resolve_dir = 1;
        tick();
        bus.resolve_valid = 0;
        n_tests++; if (bus.ckpt_full !== 1'b0 || bus.ckpt_id !== 2'd0) begin
            n_fail++; $display("FAIL full_pop got full=%b id=%0d exp full=0 id=0", bus.ckpt_full, bus.ckpt_id); end
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== IDX_W'(m_ua)) begin
            n_fail++; $display("FAIL full_upd got v=%b a=%h exp v=1 a=%h", bus.upd_valid, bus.upd_addr, m_ua); end
        tick();
        n_tests++; if (bus.ckpt_full !== 1'b1 || bus.ckpt_id !== 2'd1) begin
            n_fail++; $display("FAIL full_refill got full=%b id=%0d exp full=1 id=1", bus.ckpt_full, bus.ckpt_id); end
        bus.fetch_valid = 0;
    endtask

    task automatic test_mispredict();
        logic [31:0] pcs [3];
        logic [31:0] p0;
        do_reset();
        for (int i = 0; i < 3; i++) begin pcs[i] = $urandom; push_one(pcs[i], 1); end
        p0 = pcs[0];
        bus.fetch_valid = 1; bus.fetch_pc = $urandom; bus.pred_dir = 1;
        resolve_one(0, 0, 1, 0);
        bus.fetch_valid = 0;
        n_tests++; if (dut.r_spec_ghr !== '0) begin n_fail++; $display("FAIL mis_spec_ghr got=%h exp=000", dut.r_spec_ghr); end
        n_tests++; if (dut.u_fifo.r_count !== '0 || bus.ckpt_id !== 2'd1) begin
            n_fail++; $display("FAIL mis_queue got count=%0d id=%0d exp count=0 id=1", dut.u_fifo.r_count, bus.ckpt_id); end
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== p0[11:2] || bus.upd_dir !== 1'b0) begin
            n_fail++; $display("FAIL mis_upd got %b/%h/%b exp 1/%h/0", bus.upd_valid, bus.upd_addr, bus.upd_dir, p0[11:2]); end
        tick();
        n_tests++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b exp=0", bus.upd_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] pa;
        do_reset();
        pa = $urandom;
        push_one(pa, 1);
        push_one($urandom, 0);
        bus.fetch_valid = 1; bus.fetch_pc = $urandom;
        resolve_one(0, 1, 0, 1);
        bus.fetch_valid = 0;
        n_tests++; if (dut.r_ret_ghr !== 10'h001 || dut.r_spec_ghr !== 10'h001) begin
            n_fail++; $display("FAIL flush_ghr got ret=%h spec=%h exp 001/001", dut.r_ret_ghr, dut.r_spec_ghr); end
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== pa[11:2] || bus.upd_dir !== 1'b1) begin
            n_fail++; $display("FAIL flush_upd got %b/%h/%b exp 1/%h/1", bus.upd_valid, bus.upd_addr, bus.upd_dir, pa[11:2]); end
        n_tests++; if (dut.u_fifo.r_count !== '0 || bus.ckpt_id !== 2'd2) begin
            n_fail++; $display("FAIL flush_queue got count=%0d id=%0d exp count=0 id=2", dut.u_fifo.r_count, bus.ckpt_id); end
        tick();
        n_tests++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pulse got=%b exp=0", bus.upd_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] pa;
        int extra;
        do_reset();
        pa = $urandom;
        push_one(pa, 1);
        bus.stall = 1; bus.resolve_valid = 1; bus.resolve_id = 0; bus.resolve_dir = 1;
        bus.fetch_valid = 1; bus.fetch_pc = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.upd_valid !== 1'b0 || bus.ckpt_id !== 2'd1 || dut.r_spec_ghr !== 10'h001 || dut.r_ret_ghr !== '0) begin
                n_fail++; $display("FAIL stall_hold%0d got v=%b id=%0d spec=%h ret=%h exp 0/1/001/000", i, bus.upd_valid, bus.ckpt_id, dut.r_spec_ghr, dut.r_ret_ghr); end
        end
        bus.stall = 0; bus.fetch_valid = 0;
        tick();
        bus.resolve_valid = 0;
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== pa[11:2] || bus.upd_dir !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got %b/%h/%b exp 1/%h/1", bus.upd_valid, bus.upd_addr, bus.upd_dir, pa[11:2]); end
        extra = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.upd_valid === 1'b1) extra++; end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL stall_single_pulse got extra=%0d exp=0", extra); end
    endtask

    task automatic test_proto_err();
        logic [31:0] pcs [3];
        logic [31:0] p0, p1;
        do_reset();
        for (int i = 0; i < 3; i++) begin pcs[i] = $urandom; push_one(pcs[i], 0); end
        p0 = pcs[0]; p1 = pcs[1];
        resolve_one(2, 0, 0, 0);
        n_tests++; if (bus.proto_err !== 1'b1 || bus.upd_valid !== 1'b1 || bus.upd_addr !== p0[11:2]) begin
            n_fail++; $display("FAIL proto_bad_id got err=%b v=%b a=%h exp 1/1/%h", bus.proto_err, bus.upd_valid, bus.upd_addr, p0[11:2]); end
        resolve_one(1, 1, 0, 0);
        n_tests++; if (bus.proto_err !== 1'b1 || bus.upd_addr !== p1[11:2]) begin
            n_fail++; $display("FAIL proto_sticky got err=%b a=%h exp 1/%h", bus.proto_err, bus.upd_addr, p1[11:2]); end
        do_reset();
        n_tests++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_reset got=%b exp=0", bus.proto_err); end
        resolve_one(0, 1, 0, 0);
        n_tests++; if (bus.proto_err !== 1'b1 || bus.upd_valid !== 1'b0 || bus.ckpt_id !== 2'd0) begin
            n_fail++; $display("FAIL proto_empty got err=%b v=%b id=%0d exp 1/0/0", bus.proto_err, bus.upd_valid, bus.ckpt_id); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.stall              = ($urandom_range(0, 9) == 0);
            bus.fetch_valid        = 1'($urandom_range(0, 1));
            bus.fetch_pc           = $urandom;
            bus.pred_dir           = 1'($urandom_range(0, 1));
            bus.resolve_valid      = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            bus.resolve_id         = ($urandom_range(0, 60) == 0) ? ID_W'($urandom) : ID_W'(m_head);
            bus.resolve_dir        = 1'($urandom_range(0, 1));
            bus.resolve_mispredict = ($urandom_range(0, 4) == 0);
            bus.flush              = ($urandom_range(0, 29) == 0);
            #1;
            n_tests++; if (bus.pht_addr !== IDX_W'(exp_idx(bus.fetch_pc)) || bus.ckpt_id !== ID_W'(m_tail) || bus.ckpt_full !== (m_q.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand_comb c=%0d got a=%h id=%0d full=%b exp a=%h id=%0d full=%b", c, bus.pht_addr, bus.ckpt_id, bus.ckpt_full,
                                   exp_idx(bus.fetch_pc), m_tail, m_q.size() == DEPTH); end
            tick();
            n_tests++; if (bus.upd_valid !== m_uv || (m_uv && (bus.upd_addr !== IDX_W'(m_ua) || bus.upd_dir !== m_ud))) begin
                n_fail++; $display("FAIL rand_upd c=%0d got %b/%h/%b exp %b/%h/%b", c, bus.upd_valid, bus.upd_addr, bus.upd_dir, m_uv, m_ua, m_ud); end
            n_tests++; if (bus.proto_err !== m_proto || dut.r_spec_ghr !== HIST_W'(m_spec) || dut.r_ret_ghr !== HIST_W'(m_ret)) begin
                n_fail++; $display("FAIL rand_state c=%0d got err=%b spec=%h ret=%h exp %b/%h/%h", c, bus.proto_err, dut.r_spec_ghr, dut.r_ret_ghr,
                                   m_proto, m_spec, m_ret); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_index();
        test_full();
        test_mispredict();
        test_flush();
        test_stall();
        test_proto_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
